// File: rtl/cbus_arbiter_n_pkg.sv
// Shared CBus types and arbiter constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cbus_arbiter_n_pkg;

  // Master-to-memory request.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  // Memory-to-master response; last marks the final beat of a burst.
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

  // Arbitration modes.
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Width of each per-port age counter.
  localparam int AGE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cbus_arb_pick.sv
// Winner selection for the CBus arbiter: fixed priority with aged promotion, or round-robin.
// Latency: purely combinational.
// Backpressure: none; only reports the winner and whether one exists.
// Ports: valid (request mask), excl_en/excl_idx (port barred this cycle), rr_ptr (round-robin
//        start), age (per-port age counters), mode (ARB_FIXED/ARB_RR) -> winner, found, cand.
import cbus_arbiter_n_pkg::*;

module cbus_arb_pick #(
  parameter int NUM_PORTS = 2,
  parameter int AGE_LIMIT = 4,
  parameter int IW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]            valid,
  input  logic                            excl_en,
  input  logic [IW-1:0]                   excl_idx,
  input  logic [IW-1:0]                   rr_ptr,
  input  logic [NUM_PORTS-1:0][AGE_W-1:0] age,
  input  logic                            mode,
  output logic [IW-1:0]                   winner,
  output logic                            found,
  output logic [NUM_PORTS-1:0]            cand
);

  int idx;

  always_comb begin
    cand   = valid;
    winner = '0;
    found  = 1'b0;
    idx    = 0;

    // A finishing owner may not win the handoff it is completing.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (excl_en && (excl_idx == IW'(i))) begin
        cand[i] = 1'b0;
      end
    end

    if (mode == ARB_RR) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_PORTS) begin
          idx = idx - NUM_PORTS;
        end
        if (!found && cand[idx]) begin
          found  = 1'b1;
          winner = IW'(idx);
        end
      end
    end else begin
      // Starved ports override plain priority; lowest index wins among them.
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && cand[i] && (age[i] == AGE_W'(AGE_LIMIT))) begin
          found  = 1'b1;
          winner = IW'(i);
        end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && cand[i]) begin
          found  = 1'b1;
          winner = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter_n.sv
// N-port CBus arbiter: grants one master a whole burst, hands off with no bubble on the last beat.
// Latency: grant one cycle after request in IDLE; request/response paths combinational through sel.
// Backpressure: memory ready passes straight to the owner; other masters wait with iresps held at zero.
// Ports: clk, reset (sync, active-low), ireqs/iresps (per-master CBus), oreq/oresp (memory CBus),
//        grant (one-hot owner, 0 when idle), busy (a burst is owned).
import cbus_arbiter_n_pkg::*;

module cbus_arbiter_n #(
  parameter int NUM_PORTS = 2,
  parameter int RR_MODE   = 0,
  parameter int AGE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  cbus_req_t            ireqs  [NUM_PORTS],
  output cbus_resp_t           iresps [NUM_PORTS],
  output cbus_req_t            oreq,
  input  cbus_resp_t           oresp,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 busy
);

  localparam int   IW   = $clog2(NUM_PORTS);
  localparam logic MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_t                      state_q, state_d;
  logic [IW-1:0]                   sel_q, sel_d;
  logic [IW-1:0]                   rr_q, rr_d;
  logic [NUM_PORTS-1:0][AGE_W-1:0] age_q, age_d;

  logic [NUM_PORTS-1:0] valid_vec;
  logic [NUM_PORTS-1:0] cand;
  logic [IW-1:0]        winner;
  logic                 found;
  logic                 complete;
  logic                 take;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  cbus_arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .AGE_LIMIT (AGE_LIMIT),
    .IW        (IW)
  ) u_pick (
    .valid    (valid_vec),
    .excl_en  (state_q == BUSY),
    .excl_idx (sel_q),
    .rr_ptr   (rr_q),
    .age      (age_q),
    .mode     (MODE),
    .winner   (winner),
    .found    (found),
    .cand     (cand)
  );

  // Next state. Arbitration runs in IDLE and again in the completing cycle,
  // which is what gives back-to-back bursts without an idle bubble.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    age_d    = age_q;
    complete = (state_q == BUSY) && oresp.ready && oresp.last;
    take     = ((state_q == IDLE) || complete) && found;

    if (take) begin
      state_d = BUSY;
      sel_d   = winner;
      if (MODE == ARB_RR) begin
        rr_d = (winner == IW'(NUM_PORTS - 1)) ? '0 : winner + IW'(1);
      end else begin
        // Only ports that actually competed and lost get older.
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (winner == IW'(i)) begin
            age_d[i] = '0;
          end else if (cand[i] && (age_q[i] != AGE_W'(AGE_LIMIT))) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
      end
    end else if (complete) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      age_q   <= age_d;
    end
  end

  // Output muxing: nothing is forwarded unless a burst is owned.
  always_comb begin
    oreq  = '0;
    grant = '0;
    busy  = (state_q == BUSY);
    for (int i = 0; i < NUM_PORTS; i++) begin
      iresps[i] = '0;
      if ((state_q == BUSY) && (sel_q == IW'(i))) begin
        oreq      = ireqs[i];
        iresps[i] = oresp;
        grant[i]  = 1'b1;
      end
    end
  end

  // The owner must hold its request until its burst completes.
  owner_valid_held : assert property (
    @(posedge clk) disable iff (!reset)
    (state_q == BUSY) |-> valid_vec[sel_q]
  );

endmodule

// File: doc/cbus_arbiter_n.md
# cbus_arbiter_n

Parametrised N-port arbiter merging several CBus masters (instruction fetch, data, page-table walker, DMA) onto the single CBus toward memory, replacing the fixed two-port arbiter in the top level. Supports fixed-priority or round-robin selection, holds a grant for a whole burst, re-arbitrates in the completing cycle for zero-bubble handoff, and prevents starvation in fixed-priority mode via per-port age counters.

## Interface
- NUM_PORTS, 2: number of masters, 2..8; port 0 is highest fixed priority.
- RR_MODE, 0: 0 = fixed priority with aging, 1 = round-robin.
- AGE_LIMIT, 4: grants a waiting port may lose before forced promotion (fixed mode only), 1..15.
- clk  in  1  clock.
- reset  in  1  reset; one clock, synchronous, active-low (reset==0 resets).
- ireqs  in  cbus_req_t[NUM_PORTS]  master requests.
- iresps  out  cbus_resp_t[NUM_PORTS]  per-master responses.
- oreq  out  cbus_req_t  request to memory.
- oresp  in  cbus_resp_t  memory response.
- grant  out  NUM_PORTS  one-hot owner, 0 when idle.
- busy  out  1  a burst is owned.

## Operation
- States: IDLE, BUSY. Registers: state, sel (index), rr_ptr, age[i] (4-bit saturating).
- IDLE: if any ireqs[i].valid, pick winner W, sel<=W, state<=BUSY. Nothing forwarded in IDLE: oreq all-zero, every iresps all-zero.
- BUSY: oreq = ireqs[sel]; iresps[sel] = oresp; all other iresps all-zero. grant = onehot(sel), busy = 1.
- Completion = BUSY && oresp.ready && oresp.last. In that cycle arbitrate among valid ports excluding sel: winner exists -> sel<=winner, stay BUSY; none -> IDLE.
- Fixed-priority pick: any port with age==AGE_LIMIT wins (lowest index among those); otherwise lowest-index valid.
- Round-robin pick: first valid port scanning rr_ptr, rr_ptr+1, ... mod NUM_PORTS. On every grant rr_ptr <= (winner+1) mod NUM_PORTS.
- Aging (fixed mode): on each grant, every valid non-winner age[i] <= min(age+1, AGE_LIMIT); winner's age <= 0. Non-requesting ports keep age. Ages unused (held 0) in RR mode.
- Owner drops valid mid-burst: protocol violation; arbiter stays BUSY until completion (oreq.valid follows ireqs[sel].valid); assertion fires.
- oresp.ready without last: beat passed to owner, no state change.

## Timing
- Reset: state=IDLE, sel=0, rr_ptr=0, all age=0; oreq=0, iresps=0, grant=0, busy=0.
- Grant latency: valid at cycle t in IDLE -> oreq.valid at t+1.
- Handoff: completion at cycle t with another port waiting -> new owner's request on oreq at t+1 (no idle bubble).
- Finishing owner excluded in completion cycle even if its valid is still high; it may re-win from t+1 onward via normal arbitration (at next completion or IDLE).
- oreq/iresps are combinational from sel and inputs; no added response latency.
- Reset asserted mid-burst: next cycle all state reset values; downstream is reset in the same domain.

## Structure
- cbus_req_t, cbus_resp_t in common package (existing). Add to common: arbiter mode localparams ARB_FIXED=0, ARB_RR=1.
- One sub-module: cbus_arb_pick — combinational winner selection (valid mask, exclude index, rr_ptr, age vector, mode) -> winner index + found flag. Top holds FSM, age counters, muxing.

## Test plan
- Reset: hold reset=0 two cycles with all valids high -> grant=0, oreq.valid=0, busy=0 throughout.
- Fixed, N=2: ports 0 and 1 valid together at t, port 0 len 4 -> grant=01 at t+1, four beats routed to iresps[0] only, port 1 granted at completion+1 with no bubble.
- RR, N=4: ports 0,1,3 continuously valid, single-beat bursts -> grant order 0,1,3,0,1,3.
- Aging, N=3, AGE_LIMIT=2: ports 0 and 1 always re-requesting, port 2 valid -> port 2 granted third (after two losses), age[2] cleared to 0.
- Self-exclusion: port 0 keeps valid high in its last-beat cycle, port 1 waiting -> port 1 owns at t+1; with port 1 idle -> IDLE at t+1, port 0 regranted at t+2.
- Mid-burst reset: reset=0 on beat 2 of 4 -> next cycle grant=0, busy=0, iresps all-zero.
